// File: rtl/sram_1rw1r_pipe.sv
// Dual-port SRAM model: port A read/write with byte mask, port B read-only, shared clock.
// Latency: reads return READ_LATENCY (1 or 2) cycles after grant; writes land at the granting edge.
// Backpressure: none once ready; both grants are held low while the post-reset zero scrub runs.
module sram_1rw1r_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int NUM_WMASKS   = DATA_WIDTH / BYTE_WIDTH,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [NUM_WMASKS-1:0] a_wmask_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_req_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  init_busy_o,
  output logic                  collision_o
);

  // Reject parameter sets the model cannot represent.
  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || NUM_WMASKS != DATA_WIDTH / BYTE_WIDTH) begin : g_bad_width
    $error("sram_1rw1r_pipe: DATA_WIDTH must be NUM_WMASKS whole BYTE_WIDTH lanes");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_1rw1r_pipe: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_1rw1r_pipe: READ_LATENCY must be 1 or 2");
  end
  if (INIT_ZERO != 0 && INIT_ZERO != 1) begin : g_bad_init
    $error("sram_1rw1r_pipe: INIT_ZERO must be 0 or 1");
  end

  // DEPTH may equal 2**ADDR_WIDTH, so the range compare needs one extra bit.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;
  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   scrub_cnt_q;
  logic                    init_busy;
  logic                    scrub_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_wr_acc, a_rd_acc, b_rd_acc;
  logic                    a_in_range, b_in_range;
  logic                    collide;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_merged, b_rd_word;

  logic                    a_vld1_q, b_vld1_q, coll_q;
  logic [DATA_WIDTH-1:0]   a_dat1_q, b_dat1_q;

  // Init FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RESET_STATE;
    else         state_q <= state_d;
  end

  // Init FSM: leave INIT once the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (scrub_cnt_q == LAST_ADDR) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = RESET_STATE;
    endcase
  end

  // Init FSM: busy flag and scrub write strobe.
  always_comb begin
    init_busy = 1'b0;
    scrub_we  = 1'b0;
    if (state_q == ST_INIT) begin
      init_busy = 1'b1;
      scrub_we  = 1'b1;
    end
  end

  // Scrub address counter, restarts from word 0 on every reset and stops at DEPTH-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scrub_cnt_q <= '0;
    end else if (scrub_we) begin
      scrub_cnt_q <= (scrub_cnt_q == LAST_ADDR) ? '0 : scrub_cnt_q + 1'b1;
    end
  end

  assign init_busy_o = init_busy;
  assign a_gnt_o     = a_req_i & ~init_busy;
  assign b_gnt_o     = b_req_i & ~init_busy;

  assign a_wr_acc   = a_gnt_o & a_we_i;
  assign a_rd_acc   = a_gnt_o & ~a_we_i;
  assign b_rd_acc   = b_gnt_o;
  assign a_in_range = {1'b0, a_addr_i} < DEPTH_EXT;
  assign b_in_range = {1'b0, b_addr_i} < DEPTH_EXT;
  assign collide    = a_wr_acc & b_rd_acc & (a_addr_i == b_addr_i);

  // Out-of-range words read as zero and are never indexed into the array.
  assign a_old = a_in_range ? mem[a_addr_i] : '0;
  assign b_old = b_in_range ? mem[b_addr_i] : '0;

  // Word port A will leave behind: masked lanes from write data, the rest from the array.
  always_comb begin
    a_merged = a_old;
    for (int k = 0; k < NUM_WMASKS; k++) begin
      if (a_wmask_i[k]) a_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = a_wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Write-first: a same-address B read sees the word A is writing this cycle.
  assign b_rd_word = (collide && b_in_range) ? a_merged : b_old;

  // Array update; contents survive reset, scrub owns the array while busy.
  always_ff @(posedge clk_i) begin
    if (scrub_we) begin
      mem[scrub_cnt_q] <= '0;
    end else if (a_wr_acc && a_in_range) begin
      mem[a_addr_i] <= a_merged;
    end
  end

  // First read stage: capture data for accepted reads, hold it otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_vld1_q <= 1'b0;
      b_vld1_q <= 1'b0;
      a_dat1_q <= '0;
      b_dat1_q <= '0;
      coll_q   <= 1'b0;
    end else begin
      a_vld1_q <= a_rd_acc;
      b_vld1_q <= b_rd_acc;
      coll_q   <= collide;
      if (a_rd_acc) a_dat1_q <= a_old;
      if (b_rd_acc) b_dat1_q <= b_rd_word;
    end
  end

  assign collision_o = coll_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  a_vld2_q, b_vld2_q;
    logic [DATA_WIDTH-1:0] a_dat2_q, b_dat2_q;

    // Output register stage; data only advances with a valid beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_vld2_q <= 1'b0;
        b_vld2_q <= 1'b0;
        a_dat2_q <= '0;
        b_dat2_q <= '0;
      end else begin
        a_vld2_q <= a_vld1_q;
        b_vld2_q <= b_vld1_q;
        if (a_vld1_q) a_dat2_q <= a_dat1_q;
        if (b_vld1_q) b_dat2_q <= b_dat1_q;
      end
    end

    assign a_rvalid_o = a_vld2_q;
    assign a_rdata_o  = a_dat2_q;
    assign b_rvalid_o = b_vld2_q;
    assign b_rdata_o  = b_dat2_q;
  end else begin : g_lat1
    assign a_rvalid_o = a_vld1_q;
    assign a_rdata_o  = a_dat1_q;
    assign b_rvalid_o = b_vld1_q;
    assign b_rdata_o  = b_dat1_q;
  end

endmodule

// File: tb/tb_sram_1rw1r_pipe.sv
// Directed bench: u_dut0 is 1024 words / latency 1 / scrubbing, u_dut1 is 1000 words / latency 2 / no scrub.
// Inputs change 1 time unit after posedge; outputs are sampled at least 1 unit after posedge.
// Each comparison is an immediate assertion; one summary line at the end.
module tb_sram_1rw1r_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0 signals
  logic        rst0_n, a0_req, a0_we, b0_req;
  logic [3:0]  a0_wmask;
  logic [9:0]  a0_addr, b0_addr;
  logic [31:0] a0_wdata;
  logic        a0_gnt, a0_rvalid, b0_gnt, b0_rvalid, init0, coll0;
  logic [31:0] a0_rdata, b0_rdata;

  // Instance 1 signals
  logic        rst1_n, a1_req, a1_we, b1_req;
  logic [3:0]  a1_wmask;
  logic [9:0]  a1_addr, b1_addr;
  logic [31:0] a1_wdata;
  logic        a1_gnt, a1_rvalid, b1_gnt, b1_rvalid, init1, coll1;
  logic [31:0] a1_rdata, b1_rdata;

  sram_1rw1r_pipe #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1024),
    .READ_LATENCY(1), .INIT_ZERO(1)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst0_n),
    .a_req_i(a0_req), .a_we_i(a0_we), .a_wmask_i(a0_wmask), .a_addr_i(a0_addr),
    .a_wdata_i(a0_wdata), .a_gnt_o(a0_gnt), .a_rvalid_o(a0_rvalid), .a_rdata_o(a0_rdata),
    .b_req_i(b0_req), .b_addr_i(b0_addr), .b_gnt_o(b0_gnt), .b_rvalid_o(b0_rvalid),
    .b_rdata_o(b0_rdata), .init_busy_o(init0), .collision_o(coll0)
  );

  sram_1rw1r_pipe #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1000),
    .READ_LATENCY(2), .INIT_ZERO(0)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst1_n),
    .a_req_i(a1_req), .a_we_i(a1_we), .a_wmask_i(a1_wmask), .a_addr_i(a1_addr),
    .a_wdata_i(a1_wdata), .a_gnt_o(a1_gnt), .a_rvalid_o(a1_rvalid), .a_rdata_o(a1_rdata),
    .b_req_i(b1_req), .b_addr_i(b1_addr), .b_gnt_o(b1_gnt), .b_rvalid_o(b1_rvalid),
    .b_rdata_o(b1_rdata), .init_busy_o(init1), .collision_o(coll1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release reset on instance 0 and measure how long init_busy stays high.
  task automatic scrub0();
    int   cnt;
    logic gnt_seen;
    cnt      = 0;
    gnt_seen = 1'b0;
    rst0_n   = 1'b1;
    #1;
    while (init0 === 1'b1 && cnt < 2000) begin
      if (a0_gnt !== 1'b0) gnt_seen = 1'b1;
      cnt++;
      @(posedge clk);
      #2;
    end
    chk("scrub_cycles", cnt, 1024);
    chk("scrub_no_gnt", gnt_seen, 0);
    chk("gnt_after_scrub", a0_gnt, 1);
  endtask

  task automatic a0_wr(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] m);
    a0_req = 1'b1; a0_we = 1'b1; a0_addr = ad; a0_wdata = d; a0_wmask = m;
    step();
    a0_req = 1'b0; a0_we = 1'b0;
    chk("a0_wr_no_rvalid", a0_rvalid, 0);
  endtask

  task automatic a0_rd(input logic [9:0] ad, input logic [31:0] exp, input string tag);
    a0_req = 1'b1; a0_we = 1'b0; a0_addr = ad;
    #1 chk({tag, "_gnt"}, a0_gnt, 1);
    step();
    a0_req = 1'b0;
    chk({tag, "_vld"}, a0_rvalid, 1);
    chk(tag, a0_rdata, exp);
    step();
    chk({tag, "_vld_off"}, a0_rvalid, 0);
    chk({tag, "_hold"}, a0_rdata, exp);
  endtask

  task automatic b0_rd(input logic [9:0] ad, input logic [31:0] exp, input string tag);
    b0_req = 1'b1; b0_addr = ad;
    #1 chk({tag, "_gnt"}, b0_gnt, 1);
    step();
    b0_req = 1'b0;
    chk({tag, "_vld"}, b0_rvalid, 1);
    chk(tag, b0_rdata, exp);
    step();
    chk({tag, "_vld_off"}, b0_rvalid, 0);
  endtask

  task automatic a1_wr(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] m);
    a1_req = 1'b1; a1_we = 1'b1; a1_addr = ad; a1_wdata = d; a1_wmask = m;
    step();
    a1_req = 1'b0; a1_we = 1'b0;
  endtask

  task automatic a1_rd(input logic [9:0] ad, input logic [31:0] exp, input string tag);
    a1_req = 1'b1; a1_we = 1'b0; a1_addr = ad;
    #1 chk({tag, "_gnt"}, a1_gnt, 1);
    step();
    a1_req = 1'b0;
    chk({tag, "_vld_early"}, a1_rvalid, 0);
    step();
    chk({tag, "_vld"}, a1_rvalid, 1);
    chk(tag, a1_rdata, exp);
    step();
    chk({tag, "_vld_off"}, a1_rvalid, 0);
  endtask

  task automatic b1_rd(input logic [9:0] ad, input logic [31:0] exp, input string tag);
    b1_req = 1'b1; b1_addr = ad;
    #1 chk({tag, "_gnt"}, b1_gnt, 1);
    step();
    b1_req = 1'b0;
    chk({tag, "_vld_early"}, b1_rvalid, 0);
    step();
    chk({tag, "_vld"}, b1_rvalid, 1);
    chk(tag, b1_rdata, exp);
    step();
    chk({tag, "_vld_off"}, b1_rvalid, 0);
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    a0_req = 1'b1; a0_we = 1'b0; a0_wmask = '0; a0_addr = '0; a0_wdata = '0;
    b0_req = 1'b0; b0_addr = '0;
    a1_req = 1'b0; a1_we = 1'b0; a1_wmask = '0; a1_addr = '0; a1_wdata = '0;
    b1_req = 1'b0; b1_addr = '0;
    repeat (3) step();

    // Reset values
    chk("rst_init_busy0", init0, 1);
    chk("rst_a0_gnt", a0_gnt, 0);
    chk("rst_a0_rvalid", a0_rvalid, 0);
    chk("rst_b0_rvalid", b0_rvalid, 0);
    chk("rst_a0_rdata", a0_rdata, 0);
    chk("rst_b0_rdata", b0_rdata, 0);
    chk("rst_coll0", coll0, 0);
    chk("rst_init_busy1", init1, 0);
    chk("rst_a1_rvalid", a1_rvalid, 0);
    chk("rst_b1_rdata", b1_rdata, 0);
    rst1_n = 1'b1;

    // Scrub after power-up, dirty the top word, then reset and scrub again
    scrub0();
    a0_req = 1'b0;
    a0_wr(10'h3FF, 32'hCAFE_F00D, 4'hF);
    b0_rd(10'h3FF, 32'hCAFE_F00D, "b0_pre_scrub");
    rst0_n = 1'b0;
    #1;
    chk("rst2_init_busy", init0, 1);
    chk("rst2_b0_rdata", b0_rdata, 0);
    a0_req = 1'b1;
    step();
    scrub0();
    a0_req = 1'b0;
    b0_rd(10'h3FF, 32'h0000_0000, "scrub_3ff");

    // Byte-mask writes
    a0_wr(10'd5, 32'hDEAD_BEEF, 4'b1111);
    a0_wr(10'd5, 32'h1122_3344, 4'b0101);
    a0_rd(10'd5, 32'hDE22_BE44, "mask_rd5");

    // Collision with partial mask
    a0_wr(10'd7, 32'h1234_5678, 4'b1111);
    a0_req = 1'b1; a0_we = 1'b1; a0_addr = 10'd7; a0_wdata = 32'hAABB_CCDD; a0_wmask = 4'b0011;
    b0_req = 1'b1; b0_addr = 10'd7;
    #1 chk("coll_pre", coll0, 0);
    step();
    a0_req = 1'b0; a0_we = 1'b0; b0_req = 1'b0;
    chk("coll_b_vld", b0_rvalid, 1);
    chk("coll_b_data", b0_rdata, 32'h1234_CCDD);
    chk("coll_flag", coll0, 1);
    chk("coll_a_no_rvalid", a0_rvalid, 0);
    step();
    chk("coll_flag_off", coll0, 0);
    chk("coll_b_vld_off", b0_rvalid, 0);
    a0_rd(10'd7, 32'h1234_CCDD, "coll_a_rd7");

    // Collision with empty mask: flag still raised, old data returned
    b0_rd(10'd5, 32'hDE22_BE44, "b0_rd5");
    a0_req = 1'b1; a0_we = 1'b1; a0_addr = 10'd7; a0_wdata = 32'hFFFF_FFFF; a0_wmask = 4'b0000;
    b0_req = 1'b1; b0_addr = 10'd7;
    step();
    a0_req = 1'b0; a0_we = 1'b0; b0_req = 1'b0;
    chk("coll0m_b_data", b0_rdata, 32'h1234_CCDD);
    chk("coll0m_flag", coll0, 1);
    step();
    chk("coll0m_flag_off", coll0, 0);

    // Different addresses in the same cycle: no collision
    a0_req = 1'b1; a0_we = 1'b1; a0_addr = 10'd8; a0_wdata = 32'h0000_0055; a0_wmask = 4'b1111;
    b0_req = 1'b1; b0_addr = 10'd7;
    step();
    a0_req = 1'b0; a0_we = 1'b0; b0_req = 1'b0;
    chk("nocoll_flag", coll0, 0);
    chk("nocoll_b_data", b0_rdata, 32'h1234_CCDD);
    step();
    b0_rd(10'd8, 32'h0000_0055, "nocoll_rd8");

    // Latency-2 back-to-back reads on instance 1
    a1_wr(10'd1, 32'h0000_0011, 4'hF);
    a1_wr(10'd2, 32'h0000_0022, 4'hF);
    a1_wr(10'd3, 32'h0000_0033, 4'hF);
    a1_wr(10'd5, 32'hDE22_BE44, 4'hF);
    chk("wr_no_rvalid1", a1_rvalid, 0);
    a1_req = 1'b1; a1_we = 1'b0; a1_addr = 10'd1;
    step();
    a1_addr = 10'd2;
    chk("pipe_c1_vld", a1_rvalid, 0);
    step();
    a1_addr = 10'd3;
    chk("pipe_c2_vld", a1_rvalid, 1);
    chk("pipe_c2_data", a1_rdata, 32'h0000_0011);
    step();
    a1_req = 1'b0;
    chk("pipe_c3_vld", a1_rvalid, 1);
    chk("pipe_c3_data", a1_rdata, 32'h0000_0022);
    step();
    chk("pipe_c4_vld", a1_rvalid, 1);
    chk("pipe_c4_data", a1_rdata, 32'h0000_0033);
    step();
    chk("pipe_c5_vld", a1_rvalid, 0);
    chk("pipe_c5_hold", a1_rdata, 32'h0000_0033);

    // Reset while a B read is in flight
    b1_rd(10'd5, 32'hDE22_BE44, "b1_pre_rst");
    b1_req = 1'b1; b1_addr = 10'd5;
    step();
    b1_req = 1'b0;
    step();
    rst1_n = 1'b0;
    #1;
    chk("rst_mid_b1_vld", b1_rvalid, 0);
    chk("rst_mid_b1_data", b1_rdata, 0);
    step();
    step();
    chk("rst_mid_b1_vld2", b1_rvalid, 0);
    chk("rst_mid_init1", init1, 0);
    rst1_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_b1_vld", b1_rvalid, 0);
      chk("post_rst_b1_data", b1_rdata, 0);
    end
    b1_rd(10'd5, 32'hDE22_BE44, "keep_after_rst");

    // Out-of-range address on the 1000-word instance
    a1_wr(10'd1010, 32'hFFFF_FFFF, 4'b1111);
    a1_rd(10'd1010, 32'h0000_0000, "oor_a_rd");
    b1_rd(10'd1010, 32'h0000_0000, "oor_b_rd");
    a1_rd(10'd2, 32'h0000_0022, "oor_keep2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
